// File: rtl/rename_regfile_ckpt.sv
// rename_regfile_ckpt: register file with ROB rename tags and a circular queue of rename-state checkpoints
module rename_regfile_ckpt #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_READ = 2,
  parameter int NUM_CKPT = 4,
  parameter int CKPT_AW  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       ren_valid,
  input  logic [REG_AW-1:0]          ren_reg,
  input  logic [TAG_W-1:0]           ren_tag,
  input  logic                       cmt_valid,
  input  logic [REG_AW-1:0]          cmt_reg,
  input  logic [TAG_W-1:0]           cmt_tag,
  input  logic [DATA_W-1:0]          cmt_val,
  input  logic [NUM_READ*REG_AW-1:0] rd_id,
  output logic [NUM_READ-1:0]        rd_has_dep,
  output logic [NUM_READ*TAG_W-1:0]  rd_dep,
  output logic [NUM_READ*DATA_W-1:0] rd_val,
  output logic [NUM_READ*TAG_W-1:0]  rob_qtag,
  input  logic [NUM_READ-1:0]        rob_qready,
  input  logic [NUM_READ*DATA_W-1:0] rob_qval,
  input  logic                       ckpt_take,
  output logic [CKPT_AW-1:0]         ckpt_id,
  output logic                       ckpt_full,
  output logic [CKPT_AW:0]           ckpt_count,
  input  logic                       ckpt_release,
  input  logic                       ckpt_restore,
  input  logic [CKPT_AW-1:0]         ckpt_restore_id
);
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [TAG_W-1:0]    tags [NUM_REGS];
  logic [NUM_REGS-1:0] snap_busy [NUM_CKPT];
  logic [TAG_W-1:0]    snap_tag [NUM_CKPT][NUM_REGS];
  logic [CKPT_AW-1:0]  head, tail;
  logic [CKPT_AW:0]    count;
  logic [NUM_REGS-1:0] busy_nx;
  logic [TAG_W-1:0]    tags_nx [NUM_REGS];
  logic                ren_ok, cmt_ok, do_take, do_rel;
  assign ren_ok     = ren_valid && ren_reg != '0;
  assign cmt_ok     = cmt_valid && cmt_reg != '0;
  assign ckpt_full  = count == (CKPT_AW+1)'(NUM_CKPT);
  assign ckpt_count = count;
  assign ckpt_id    = tail;
  assign do_rel     = ckpt_release && count != '0;
  assign do_take    = ckpt_take && (!ckpt_full || do_rel);
  // Restore starts from the snapshot, normal cycles from live state; commit clear hits either, rename only the latter
  always_comb begin
    busy_nx = ckpt_restore ? snap_busy[ckpt_restore_id] : busy;
    tags_nx = ckpt_restore ? snap_tag[ckpt_restore_id] : tags;
    if (cmt_ok && busy_nx[cmt_reg] && tags_nx[cmt_reg] == cmt_tag) busy_nx[cmt_reg] = 1'b0;
    if (!ckpt_restore && ren_ok) begin
      busy_nx[ren_reg] = 1'b1;
      tags_nx[ren_reg] = ren_tag;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
        tags[r] <= '0;
      end
      for (int k = 0; k < NUM_CKPT; k++) begin
        snap_busy[k] <= '0;
        for (int r = 0; r < NUM_REGS; r++) snap_tag[k][r] <= '0;
      end
    end else if (rdy) begin
      if (cmt_ok) regs[cmt_reg] <= cmt_val;
      if (flush) begin
        busy  <= '0;
        head  <= tail;
        count <= '0;
        for (int r = 0; r < NUM_REGS; r++) tags[r] <= '0;
      end else begin
        busy <= busy_nx;
        tags <= tags_nx;
        for (int k = 0; k < NUM_CKPT; k++)
          if (cmt_ok && snap_tag[k][cmt_reg] == cmt_tag) snap_busy[k][cmt_reg] <= 1'b0;
        if (ckpt_restore) begin
          tail  <= ckpt_restore_id;
          count <= {1'b0, ckpt_restore_id - head};
        end else begin
          if (do_take) begin
            snap_busy[tail] <= busy_nx;
            snap_tag[tail]  <= tags_nx;
            tail            <= tail + 1'b1;
          end
          if (do_rel) head <= head + 1'b1;
          count <= count + (CKPT_AW+1)'(do_take) - (CKPT_AW+1)'(do_rel);
        end
      end
    end
  end
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [REG_AW-1:0] id;
    logic [TAG_W-1:0]  t;
    logic              b, fwd;
    assign id  = rd_id[i*REG_AW +: REG_AW];
    assign b   = id != '0 && busy[id];
    assign t   = b ? tags[id] : '0;
    assign fwd = b && cmt_valid && cmt_reg == id && cmt_tag == t;
    assign rd_dep[i*TAG_W +: TAG_W]   = t;
    assign rob_qtag[i*TAG_W +: TAG_W] = t;
    assign rd_has_dep[i]              = b && !fwd && !rob_qready[i];
    assign rd_val[i*DATA_W +: DATA_W] = !b ? regs[id] : fwd ? cmt_val :
                                        rob_qready[i] ? rob_qval[i*DATA_W +: DATA_W] : '0;
  end
endmodule

// File: tb/tb_rename_regfile_ckpt.sv
// tb_rename_regfile_ckpt: directed scenario tasks with inline checks for rename_regfile_ckpt
module tb_rename_regfile_ckpt;
  logic        clk = 0, rst_n = 0, rdy = 1, flush = 0;
  logic        ren_valid = 0, cmt_valid = 0;
  logic [4:0]  ren_reg = 0, cmt_reg = 0;
  logic [3:0]  ren_tag = 0, cmt_tag = 0;
  logic [31:0] cmt_val = 0;
  logic [9:0]  rd_id = 0;
  logic [1:0]  rd_has_dep, rob_qready = 0;
  logic [7:0]  rd_dep, rob_qtag;
  logic [63:0] rd_val, rob_qval = 0;
  logic        ckpt_take = 0, ckpt_full, ckpt_release = 0, ckpt_restore = 0;
  logic [1:0]  ckpt_id, ckpt_restore_id = 0;
  logic [2:0]  ckpt_count;
  int checks = 0, failures = 0;

  rename_regfile_ckpt dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .ren_valid(ren_valid), .ren_reg(ren_reg), .ren_tag(ren_tag),
    .cmt_valid(cmt_valid), .cmt_reg(cmt_reg), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
    .rd_id(rd_id), .rd_has_dep(rd_has_dep), .rd_dep(rd_dep), .rd_val(rd_val),
    .rob_qtag(rob_qtag), .rob_qready(rob_qready), .rob_qval(rob_qval),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_count(ckpt_count),
    .ckpt_release(ckpt_release), .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; ren_valid = 0; cmt_valid = 0; ckpt_take = 0; ckpt_release = 0;
    ckpt_restore = 0; rob_qready = 0; rob_qval = 0; rdy = 1;
  endtask

  task automatic ren(input logic [4:0] r, input logic [3:0] t);
    ren_valid = 1; ren_reg = r; ren_tag = t;
  endtask

  task automatic cmt(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
    cmt_valid = 1; cmt_reg = r; cmt_tag = t; cmt_val = v;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    rd_id = {5'd0, 5'd5};
    #3;
    checks++; if (rd_has_dep !== 2'b00) begin failures++; $display("FAIL reset_dep got=%b exp=00", rd_has_dep); end
    checks++; if (rd_val !== 64'h0) begin failures++; $display("FAIL reset_val got=%h exp=0", rd_val); end
    checks++; if (ckpt_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ckpt_count); end
    checks++; if (ckpt_full !== 1'b0 || ckpt_id !== 2'd0) begin failures++; $display("FAIL reset_ckpt got full=%b id=%0d exp 0/0", ckpt_full, ckpt_id); end
    @(negedge clk) rst_n = 1;
    tick();
  endtask

  task automatic test_rob_fwd();
    ren(5'd5, 4'd3); tick(); ren(5'd0, 4'd9); tick(); idle();
    rd_id = {5'd0, 5'd5}; #1;
    checks++; if (rd_has_dep !== 2'b01) begin failures++; $display("FAIL rob_pending got=%b exp=01", rd_has_dep); end
    checks++; if (rd_dep[3:0] !== 4'd3 || rob_qtag[3:0] !== 4'd3) begin failures++; $display("FAIL rob_dep got=%0d/%0d exp=3", rd_dep[3:0], rob_qtag[3:0]); end
    checks++; if (rd_dep[7:4] !== 4'd0 || rd_val[63:32] !== 32'h0) begin failures++; $display("FAIL x0_rename got dep=%0d val=%h exp 0", rd_dep[7:4], rd_val[63:32]); end
    rob_qready = 2'b01; rob_qval = {32'h0, 32'hAB}; #1;
    checks++; if (rd_has_dep[0] !== 1'b0 || rd_val[31:0] !== 32'hAB) begin failures++; $display("FAIL rob_ready got dep=%b val=%h exp 0/ab", rd_has_dep[0], rd_val[31:0]); end
    idle();
  endtask

  task automatic test_commit();
    rd_id = {5'd0, 5'd5};
    cmt(5'd5, 4'd3, 32'h55); #1;
    checks++; if (rd_has_dep[0] !== 1'b0 || rd_val[31:0] !== 32'h55) begin failures++; $display("FAIL cmt_bypass got dep=%b val=%h exp 0/55", rd_has_dep[0], rd_val[31:0]); end
    tick(); idle(); #1;
    checks++; if (rd_has_dep[0] !== 1'b0 || rd_val[31:0] !== 32'h55) begin failures++; $display("FAIL cmt_write got dep=%b val=%h exp 0/55", rd_has_dep[0], rd_val[31:0]); end
    ren(5'd5, 4'd6); tick(); idle();
    cmt(5'd5, 4'd6, 32'h66); ren(5'd5, 4'd7); tick(); idle(); #1;
    checks++; if (rd_has_dep[0] !== 1'b1 || rd_dep[3:0] !== 4'd7) begin failures++; $display("FAIL cmt_ren_same got dep=%b tag=%0d exp 1/7", rd_has_dep[0], rd_dep[3:0]); end
    cmt(5'd5, 4'd6, 32'h99); tick(); idle(); #1;
    checks++; if (rd_has_dep[0] !== 1'b1 || rd_dep[3:0] !== 4'd7) begin failures++; $display("FAIL cmt_stale_tag got dep=%b tag=%0d exp 1/7", rd_has_dep[0], rd_dep[3:0]); end
    cmt(5'd5, 4'd7, 32'h77); tick(); idle(); #1;
    checks++; if (rd_has_dep[0] !== 1'b0 || rd_val[31:0] !== 32'h77) begin failures++; $display("FAIL cmt_clear got dep=%b val=%h exp 0/77", rd_has_dep[0], rd_val[31:0]); end
  endtask

  task automatic test_restore();
    ren(5'd1, 4'd1); tick(); idle();
    checks++; if (ckpt_id !== 2'd0) begin failures++; $display("FAIL take_id got=%0d exp=0", ckpt_id); end
    ckpt_take = 1; tick(); idle();
    checks++; if (ckpt_count !== 3'd1 || ckpt_id !== 2'd1) begin failures++; $display("FAIL take_count got cnt=%0d id=%0d exp 1/1", ckpt_count, ckpt_id); end
    ren(5'd1, 4'd2); tick(); ren(5'd2, 4'd3); tick(); idle();
    rd_id = {5'd2, 5'd1}; #1;
    checks++; if (rd_has_dep !== 2'b11 || rd_dep !== 8'h32) begin failures++; $display("FAIL pre_restore got dep=%b tags=%h exp 11/32", rd_has_dep, rd_dep); end
    ckpt_restore = 1; ckpt_restore_id = 2'd0; ren(5'd2, 4'd8); ckpt_take = 1; tick(); idle(); #1;
    checks++; if (rd_has_dep !== 2'b01 || rd_dep[3:0] !== 4'd1) begin failures++; $display("FAIL restore_tables got dep=%b tag=%0d exp 01/1", rd_has_dep, rd_dep[3:0]); end
    checks++; if (ckpt_count !== 3'd0 || ckpt_id !== 2'd0) begin failures++; $display("FAIL restore_queue got cnt=%0d id=%0d exp 0/0", ckpt_count, ckpt_id); end
    cmt(5'd1, 4'd1, 32'h11); tick(); idle();
  endtask

  task automatic test_full();
    ckpt_take = 1;
    repeat (4) tick();
    checks++; if (ckpt_count !== 3'd4 || ckpt_full !== 1'b1 || ckpt_id !== 2'd0) begin failures++; $display("FAIL full got cnt=%0d full=%b id=%0d exp 4/1/0", ckpt_count, ckpt_full, ckpt_id); end
    tick();
    checks++; if (ckpt_count !== 3'd4 || ckpt_id !== 2'd0) begin failures++; $display("FAIL take_when_full got cnt=%0d id=%0d exp 4/0", ckpt_count, ckpt_id); end
    ckpt_release = 1; tick(); idle();
    checks++; if (ckpt_count !== 3'd4 || ckpt_id !== 2'd1 || ckpt_full !== 1'b1) begin failures++; $display("FAIL rel_take_full got cnt=%0d id=%0d full=%b exp 4/1/1", ckpt_count, ckpt_id, ckpt_full); end
    ckpt_release = 1; tick(); idle();
    checks++; if (ckpt_count !== 3'd3 || ckpt_full !== 1'b0) begin failures++; $display("FAIL release got cnt=%0d full=%b exp 3/0", ckpt_count, ckpt_full); end
    flush = 1; tick(); idle();
    ckpt_release = 1; tick(); idle();
    checks++; if (ckpt_count !== 3'd0 || ckpt_id !== 2'd1) begin failures++; $display("FAIL rel_empty got cnt=%0d id=%0d exp 0/1", ckpt_count, ckpt_id); end
  endtask

  task automatic test_restore_commit();
    rd_id = {5'd0, 5'd4};
    ren(5'd4, 4'd5); tick(); idle();
    ckpt_take = 1; tick(); idle();
    cmt(5'd4, 4'd5, 32'd9); tick(); idle();
    ckpt_restore = 1; ckpt_restore_id = 2'd1; tick(); idle(); #1;
    checks++; if (rd_has_dep[0] !== 1'b0 || rd_val[31:0] !== 32'd9) begin failures++; $display("FAIL restore_after_cmt got dep=%b val=%h exp 0/9", rd_has_dep[0], rd_val[31:0]); end
    checks++; if (ckpt_count !== 3'd0 || ckpt_id !== 2'd1) begin failures++; $display("FAIL restore_after_cmt_q got cnt=%0d id=%0d exp 0/1", ckpt_count, ckpt_id); end
    ren(5'd4, 4'd6); tick(); idle();
    ckpt_take = 1; tick(); idle();
    ckpt_restore = 1; ckpt_restore_id = 2'd1; cmt(5'd4, 4'd6, 32'h2A); tick(); idle(); #1;
    checks++; if (rd_has_dep[0] !== 1'b0 || rd_val[31:0] !== 32'h2A) begin failures++; $display("FAIL restore_same_cmt got dep=%b val=%h exp 0/2a", rd_has_dep[0], rd_val[31:0]); end
  endtask

  task automatic test_flush();
    ren(5'd3, 4'd2); tick(); idle();
    ren(5'd6, 4'd4); ckpt_take = 1; tick(); idle();
    rd_id = {5'd6, 5'd3}; #1;
    checks++; if (rd_has_dep !== 2'b11 || ckpt_count !== 3'd1) begin failures++; $display("FAIL pre_flush got dep=%b cnt=%0d exp 11/1", rd_has_dep, ckpt_count); end
    flush = 1; cmt(5'd7, 4'd0, 32'h70); ren(5'd3, 4'd5); tick(); idle(); #1;
    checks++; if (rd_has_dep !== 2'b00 || ckpt_count !== 3'd0) begin failures++; $display("FAIL flush got dep=%b cnt=%0d exp 00/0", rd_has_dep, ckpt_count); end
    rd_id = {5'd0, 5'd7}; #1;
    checks++; if (rd_val[31:0] !== 32'h70) begin failures++; $display("FAIL flush_cmt got=%h exp=70", rd_val[31:0]); end
  endtask

  task automatic test_rdy();
    rdy = 0; ren(5'd8, 4'd1); cmt(5'd9, 4'd0, 32'd5); ckpt_take = 1; tick(); idle();
    rd_id = {5'd9, 5'd8}; #1;
    checks++; if (rd_has_dep[0] !== 1'b0 || rd_val[63:32] !== 32'h0) begin failures++; $display("FAIL rdy_hold got dep=%b val=%h exp 0/0", rd_has_dep[0], rd_val[63:32]); end
    checks++; if (ckpt_count !== 3'd0) begin failures++; $display("FAIL rdy_count got=%0d exp=0", ckpt_count); end
  endtask

  task automatic test_async_reset();
    ren(5'd10, 4'd9); ckpt_take = 1; tick(); idle();
    rd_id = {5'd0, 5'd10}; #1;
    checks++; if (rd_has_dep[0] !== 1'b1 || ckpt_count !== 3'd1) begin failures++; $display("FAIL pre_rst got dep=%b cnt=%0d exp 1/1", rd_has_dep[0], ckpt_count); end
    rst_n = 0; #1;
    checks++; if (rd_has_dep[0] !== 1'b0 || ckpt_count !== 3'd0 || ckpt_id !== 2'd0) begin failures++; $display("FAIL async_rst got dep=%b cnt=%0d id=%0d exp 0/0/0", rd_has_dep[0], ckpt_count, ckpt_id); end
    rd_id = {5'd0, 5'd5}; #1;
    checks++; if (rd_val[31:0] !== 32'h0) begin failures++; $display("FAIL async_rst_val got=%h exp=0", rd_val[31:0]); end
    @(negedge clk) rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_rob_fwd();
    test_commit();
    test_restore();
    test_full();
    test_restore_commit();
    test_flush();
    test_rdy();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
